sprite_scheduler: RTL
=====================

// Module: sprite_scheduler
// PURPOSE
// Time-multiplexes one bounce-physics unit across NUM_SPRITES boxes, once per frame, and arbitrates which box owns each pixel.
// Sits between video_timer (frame, position_*_next) and the top-level visible gating of r/g/b.
// Double-buffered: physics writes a working copy; the render side reads a committed copy, so no mid-frame tearing.
// PARAMETERS
// NUM_SPRITES    4    number of boxes (1..8); index width IW = max(1,$clog2(NUM_SPRITES))
// SCREEN_WIDTH   640  visible pixels per line
// SCREEN_HEIGHT  480  visible lines per frame
// BOX_WIDTH      100  box width in pixels (all sprites)
// BOX_HEIGHT     100  box height in pixels (all sprites)
// PORTS
// clk              in   1   pixel clock
// rst              in   1   asynchronous reset, active-low (0 = reset)
// frame            in   32  frame counter from video_timer
// position_x_next  in   10  next-cycle pixel x
// position_y_next  in   9   next-cycle pixel y
// r, g, b          out  4   registered pixel colour, aligned with position_x/position_y
// busy             out  1   physics sweep in progress
// update_done      out  1   one-cycle pulse after commit of a full sweep
// overrun          out  1   sticky: frame advanced during a sweep
// BEHAVIOUR
// - Reset (async, rst=0): FSM=IDLE, idx=0, busy=0, update_done=0, overrun=0, pending=0, primed=0, r=g=b=0.
//   Sprite i (working and committed copies): x=50+120*i, y=50+60*i, xv=(i odd ? -2 : +2), yv=+1, color=(i%7)+1.
// - First cycle with rst=1 and primed=0: frame_prev<=frame, primed<=1, no trigger.
// - FSM: IDLE -> READ -> WRITE -> (READ | IDLE).
//   IDLE: if primed && frame!=frame_prev: frame_prev<=frame, idx<=0, go READ.
//   READ: latch working[idx] into the physics input register.
//   WRITE: working[idx]<=physics result; if idx==NUM_SPRITES-1: commit all (working incl. this write) to committed,
//     then go READ with idx=0 if pending (pending<=0), else IDLE; otherwise idx++, go READ.
// - Timing: trigger seen at cycle t -> busy=1 cycles t+1..t+2*NUM_SPRITES; update_done=1 at t+2*NUM_SPRITES+1.
// - busy = (state!=IDLE); update_done registered, high exactly one cycle per completed sweep.
// - frame!=frame_prev while busy: frame_prev<=frame, pending<=1, overrun<=1 (sticky until reset); further changes merge.
// - Physics (signed, x 11b, y 10b, v 11b/10b two's complement): tx=x+xv, ty=y+yv.
//   tx<0: x=0, xv=-xv; tx>SCREEN_WIDTH-BOX_WIDTH: x=SCREEN_WIDTH-BOX_WIDTH, xv=-xv; else x=tx. Same for y with heights.
//   Any bounce: color = (color==7) ? 1 : color+1; color never 0.
// - Render (committed copy only): in_box(i) = x_i<=px<x_i+BOX_WIDTH && y_i<=py<y_i+BOX_HEIGHT, px/py=position_*_next.
//   Lowest index with in_box wins: r={4{c[0]}}, g={4{c[1]}}, b={4{c[2]}}; no hit: r=g=b=4'h1. Output registered, latency 1.
// - Commit and render read in same cycle: render uses pre-commit values (new ones visible next cycle).
// STRUCTURE
// - screensaver_pkg: sprite_t {x, y, xv, yv, color}, MAX_X/MAX_Y localparams, sprite_init(i) function, state enum.
// - Sub-module sprite_physics: combinational sprite_t -> sprite_t bounce update; instantiated once.
// - Working/committed arrays and pixel arbiter stay in sprite_scheduler.
// TESTING
// - Reset release, frame held: no busy for 100 cycles; r/g/b at (60,60) = 4'hF/0/0 (sprite0 color 1) one cycle later.
// - Single frame step (N=4): busy high exactly 8 cycles, update_done 1 cycle; sprite0 committed x=52,y=51.
// - Right-edge bounce: sprite x=539,xv=+2 -> x=540, xv=-2, color 3->4; next sweep x=538.
// - Top-edge bounce with color 7: y=0,yv=-1 -> y=0, yv=+1, color=1.
// - Frame toggles twice during sweep -> overrun=1, one extra back-to-back sweep (busy 16 cycles contiguous).
// - Overlap (sprites 0,1 both cover pixel): sprite0 color wins; rst=0 mid-sweep -> all outputs reset values immediately.

Source files
------------

// File: rtl/screensaver_pkg.sv
// Shared types for the sprite scheduler.
//   sprite_t    : per-box state (position, velocity, colour)
//   state_t     : physics sweep FSM states
//   MAX_X/MAX_Y : default bounce limits for a 640x480 screen with 100x100 boxes
//   sprite_init : power-on state of box i
package screensaver_pkg;

  localparam int MAX_X = 640 - 100;
  localparam int MAX_Y = 480 - 100;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic signed [10:0] xv;
    logic signed [9:0]  yv;
    logic [2:0]         color;
  } sprite_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Boxes start on a diagonal, alternating horizontal direction.
  function automatic sprite_t sprite_init(input int i);
    sprite_t s;
    s.x     = 11'(50 + 120 * i);
    s.y     = 10'(50 + 60 * i);
    s.xv    = (i % 2 == 1) ? -11'sd2 : 11'sd2;
    s.yv    = 10'sd1;
    s.color = 3'((i % 7) + 1);
    return s;
  endfunction

endpackage

// File: rtl/sprite_physics.sv
// Combinational bounce update for one box.
//   s_i : current sprite state
//   s_o : state after one step; position clamped to [0, limit] with the
//         velocity component reversed on contact, colour advanced on any bounce
module sprite_physics
  import screensaver_pkg::*;
#(
  parameter int X_LIMIT = MAX_X,
  parameter int Y_LIMIT = MAX_Y
) (
  input  sprite_t s_i,
  output sprite_t s_o
);

  // One extra bit so the trial position cannot wrap.
  logic signed [11:0] tx;
  logic signed [10:0] ty;
  logic               bx;
  logic               by;

  always_comb begin
    tx  = 12'(s_i.x) + 12'(s_i.xv);
    ty  = 11'(s_i.y) + 11'(s_i.yv);
    s_o = s_i;
    bx  = 1'b0;
    by  = 1'b0;

    if (tx < 0) begin
      s_o.x  = '0;
      s_o.xv = -s_i.xv;
      bx     = 1'b1;
    end else if (tx > 12'(X_LIMIT)) begin
      s_o.x  = 11'(X_LIMIT);
      s_o.xv = -s_i.xv;
      bx     = 1'b1;
    end else begin
      s_o.x  = tx[10:0];
    end

    if (ty < 0) begin
      s_o.y  = '0;
      s_o.yv = -s_i.yv;
      by     = 1'b1;
    end else if (ty > 11'(Y_LIMIT)) begin
      s_o.y  = 10'(Y_LIMIT);
      s_o.yv = -s_i.yv;
      by     = 1'b1;
    end else begin
      s_o.y  = ty[9:0];
    end

    // Colour cycles 1..7 and never becomes 0 (black box).
    if (bx || by) begin
      s_o.color = (s_i.color == 3'd7) ? 3'd1 : s_i.color + 3'd1;
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Time-multiplexes one sprite_physics unit over NUM_SPRITES boxes once per
// frame and arbitrates pixel ownership for rendering.
//   clk             : pixel clock
//   rst             : asynchronous reset, active-low
//   frame           : frame counter; any change requests a physics sweep
//   position_x_next : pixel x of the next cycle
//   position_y_next : pixel y of the next cycle
//   r, g, b         : registered pixel colour (1-cycle latency)
//   busy            : physics sweep in progress
//   update_done     : one-cycle pulse after each sweep is committed
//   overrun         : sticky, frame advanced while a sweep was running
// The physics writes a working copy; the renderer reads only the committed
// copy, refreshed atomically at the end of each sweep.
module sprite_scheduler
  import screensaver_pkg::*;
#(
  parameter int NUM_SPRITES   = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BOX_WIDTH     = 100,
  parameter int BOX_HEIGHT    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame,
  input  logic [9:0]  position_x_next,
  input  logic [8:0]  position_y_next,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        busy,
  output logic        update_done,
  output logic        overrun
);

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          pending_q;
  logic          primed_q;
  logic [31:0]   frame_prev_q;
  logic          update_done_q;
  logic          overrun_q;
  sprite_t       phys_in_q;
  sprite_t       phys_out;
  sprite_t       work_q [NUM_SPRITES];
  sprite_t       comm_q [NUM_SPRITES];
  logic [11:0]   rgb_d;
  logic [11:0]   rgb_q;
  logic          frame_chg;

  sprite_physics #(
    .X_LIMIT(SCREEN_WIDTH - BOX_WIDTH),
    .Y_LIMIT(SCREEN_HEIGHT - BOX_HEIGHT)
  ) u_physics (
    .s_i(phys_in_q),
    .s_o(phys_out)
  );

  assign frame_chg = (frame != frame_prev_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      primed_q      <= 1'b0;
      frame_prev_q  <= '0;
      update_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      phys_in_q     <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        work_q[i] <= sprite_init(i);
        comm_q[i] <= sprite_init(i);
      end
    end else begin
      update_done_q <= 1'b0;
      if (!primed_q) begin
        // Capture the current frame so the first observed value is not a trigger.
        primed_q     <= 1'b1;
        frame_prev_q <= frame;
      end else begin
        // Frame changes during a sweep collapse into a single follow-up sweep.
        if (state_q != S_IDLE && frame_chg) begin
          frame_prev_q <= frame;
          pending_q    <= 1'b1;
          overrun_q    <= 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (frame_chg) begin
              frame_prev_q <= frame;
              idx_q        <= '0;
              state_q      <= S_READ;
            end
          end
          S_READ: begin
            phys_in_q <= work_q[idx_q];
            state_q   <= S_WRITE;
          end
          S_WRITE: begin
            work_q[idx_q] <= phys_out;
            if (idx_q == LAST) begin
              // Commit includes the box being written this cycle.
              for (int i = 0; i < NUM_SPRITES; i++) begin
                comm_q[i] <= work_q[i];
              end
              comm_q[LAST]  <= phys_out;
              update_done_q <= 1'b1;
              idx_q         <= '0;
              // A change seen on this very cycle must not be dropped.
              if (pending_q || frame_chg) begin
                pending_q <= 1'b0;
                state_q   <= S_READ;
              end else begin
                state_q   <= S_IDLE;
              end
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= S_READ;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  function automatic logic in_box(input sprite_t s, input logic [9:0] px,
                                  input logic [8:0] py);
    logic signed [12:0] sx;
    logic signed [12:0] sy;
    logic signed [12:0] pxs;
    logic signed [12:0] pys;
    sx  = 13'(s.x);
    sy  = 13'(s.y);
    pxs = $signed({3'b000, px});
    pys = $signed({4'b0000, py});
    return (sx <= pxs) && (pxs < sx + 13'(BOX_WIDTH)) &&
           (sy <= pys) && (pys < sy + 13'(BOX_HEIGHT));
  endfunction

  // Scan from the top index down so the lowest-index hit wins.
  always_comb begin
    rgb_d = 12'h111;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (in_box(comm_q[i], position_x_next, position_y_next)) begin
        rgb_d = {{4{comm_q[i].color[0]}}, {4{comm_q[i].color[1]}},
                 {4{comm_q[i].color[2]}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];
  assign busy        = (state_q != S_IDLE);
  assign update_done = update_done_q;
  assign overrun     = overrun_q;

endmodule
